ifu_pc_gen: RTL



---
 rtl/ifu_pc_gen_pkg.sv | 24 ++
 rtl/ifu_pc_gen_npc_calc.sv | 43 ++++
 rtl/ifu_pc_gen.sv | 83 ++++++++
 3 files changed

// File: rtl/ifu_pc_gen_pkg.sv
// Shared encodings and constants for the instruction-fetch PC generator.
// Also provides the IM window upper bound helper used by the legality check.
package ifu_pc_gen_pkg;

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    // Address of the last legal word in the IM window.
    function automatic logic [31:0] im_last_addr(input logic [31:0] base,
                                                 input int unsigned depth);
        return base + (depth * 32'd4) - 32'd4;
    endfunction

endpackage

// File: rtl/ifu_pc_gen_npc_calc.sv
// Combinational next-PC mux and fetch-address legality check.
module ifu_pc_gen_npc_calc
    import ifu_pc_gen_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int unsigned IM_DEPTH = 1024
) (
    input  logic [31:0] i_pc,
    input  logic [1:0]  i_npc_sel,
    input  logic        i_br_taken,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_imm26,
    input  logic [31:0] i_ra_data,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_npc,
    output logic        o_legal
);

    localparam logic [31:0] PC_LAST = im_last_addr(PC_RESET, IM_DEPTH);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_npc;

    assign w_pc_plus4 = i_pc + 32'd4;
    assign w_br_off   = {{14{i_imm16[15]}}, i_imm16, 2'b00};

    always_comb begin
        w_npc = w_pc_plus4;
        case (i_npc_sel)
            NPC_SEQ: w_npc = w_pc_plus4;
            NPC_BR:  w_npc = i_br_taken ? (w_pc_plus4 + w_br_off) : w_pc_plus4;
            NPC_J:   w_npc = {w_pc_plus4[31:28], i_imm26, 2'b00};
            NPC_JR:  w_npc = i_ra_data;
            default: w_npc = w_pc_plus4;
        endcase
    end

    assign o_pc_plus4 = w_pc_plus4;
    assign o_npc      = w_npc;
    assign o_legal    = (w_npc[1:0] == 2'b00) && (w_npc >= PC_RESET) && (w_npc <= PC_LAST);

endmodule

// File: rtl/ifu_pc_gen.sv
// Instruction-fetch PC generator: PC register, RUN/HALT/FAULT state and fetch counter.
// HALT and FAULT freeze all state until reset.
module ifu_pc_gen
    import ifu_pc_gen_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int unsigned IM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    input  logic [1:0]  i_npc_sel,
    input  logic        i_br_taken,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_imm26,
    input  logic [31:0] i_ra_data,
    input  logic        i_halt_req,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_npc,
    output logic        o_pc_err,
    output logic        o_halted,
    output logic [31:0] o_instr_cnt
);

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr_cnt;
    logic        r_pc_err;
    logic        r_halted;
    logic        w_legal;

    ifu_pc_gen_npc_calc #(
        .PC_RESET (PC_RESET),
        .IM_DEPTH (IM_DEPTH)
    ) u_npc_calc (
        .i_pc       (r_pc),
        .i_npc_sel  (i_npc_sel),
        .i_br_taken (i_br_taken),
        .i_imm16    (i_imm16),
        .i_imm26    (i_imm26),
        .i_ra_data  (i_ra_data),
        .o_pc_plus4 (o_pc_plus4),
        .o_npc      (o_npc),
        .o_legal    (w_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_pc        <= PC_RESET;
            r_instr_cnt <= 32'd0;
            r_pc_err    <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // halt_req wins over both the PC load and the legality check
                    if (i_en) begin
                        if (i_halt_req) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else if (!w_legal) begin
                            r_state  <= S_FAULT;
                            r_halted <= 1'b1;
                            r_pc_err <= 1'b1;
                        end else begin
                            r_pc        <= o_npc;
                            r_instr_cnt <= r_instr_cnt + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_pc        = r_pc;
    assign o_pc_err    = r_pc_err;
    assign o_halted    = r_halted;
    assign o_instr_cnt = r_instr_cnt;

endmodule
